// File: rtl/lbp_engine_param.sv
// lbp_engine_param: parametrised local-binary-pattern engine.
// Streams a grey image column-wise (three rows per column) from an external
// memory. It keeps a sliding 3x3 window and writes one 8-bit LBP code per
// interior pixel.
// Optional build macro LBP_BORDER_WR_EN: when defined, a BORDER state first
// writes code 0 to every border address (ascending) before fetching starts.
module lbp_engine_param #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [PIX_W-1:0]  gray_data,
    input  logic [PIX_W-1:0]  thr,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_A    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);
`ifdef LBP_BORDER_WR_EN
    localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BORDER = 2'd1, FETCH = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_t;
`endif

    // Linear address of (row, col); wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] r,
                                                  input logic [ADDR_W-1:0] c);
        logic [ADDR_W-1:0] w;
        w = ADDR_W'(IMG_W);
        return r * w + c;
    endfunction

    state_t            state_r;
    logic [ADDR_W-1:0] row_r;
    logic [ADDR_W-1:0] col_r;
    logic [1:0]        ph_r;      // 0: row above, 1: centre row, 2: row below
    logic              last_r;    // final result cycle of the frame
    logic [PIX_W-1:0]  thr_r;
    logic [PIX_W-1:0]  top_r;     // staging for the column being fetched
    logic [PIX_W-1:0]  mid_r;
    logic [PIX_W-1:0]  left_r [3]; // column c-2 (index 0 top .. 2 bottom)
    logic [PIX_W-1:0]  cent_r [3]; // column c-1

    logic              last_col_s;
    logic              frame_end_s;
    logic [1:0]        nph_s;
    logic [ADDR_W-1:0] ncol_s;
    logic [ADDR_W-1:0] nrow_s;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic [PIX_W:0]    thr_sum_s;
    logic [PIX_W-1:0]  nb_s [8];
    logic [7:0]        code_s;

    assign last_col_s  = (col_r == W_LAST);
    assign frame_end_s = (ph_r == 2'd2) && last_col_s && (row_r == ROW_LAST);

    // Next fetch position: walk rows r-1, r, r+1 of a column, then step column/row.
    always_comb begin
        nph_s  = ph_r;
        ncol_s = col_r;
        nrow_s = row_r;
        if (ph_r != 2'd2) begin
            nph_s = ph_r + 2'd1;
        end else begin
            nph_s = 2'd0;
            if (last_col_s) begin
                ncol_s = '0;
                nrow_s = row_r + ONE_A;
            end else begin
                ncol_s = col_r + ONE_A;
            end
        end
        fetch_addr_s = addr_of(nrow_s - ONE_A + ADDR_W'(nph_s), ncol_s);
    end

    // LBP code for the window whose right column is {top_r, mid_r, gray_data}.
    always_comb begin
        thr_sum_s = {1'b0, cent_r[1]} + {1'b0, thr_r};
        nb_s[0] = left_r[0];
        nb_s[1] = cent_r[0];
        nb_s[2] = top_r;
        nb_s[3] = left_r[1];
        nb_s[4] = mid_r;
        nb_s[5] = left_r[2];
        nb_s[6] = cent_r[2];
        nb_s[7] = gray_data;
        code_s  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            code_s[k] = ({1'b0, nb_s[k]} >= thr_sum_s);
        end
    end

`ifdef LBP_BORDER_WR_EN
    logic [ADDR_W-1:0] brow_s;
    logic [ADDR_W-1:0] bcol_s;
    logic              border_end_s;

    // Next border position in ascending address order.
    always_comb begin
        brow_s       = row_r;
        bcol_s       = col_r;
        border_end_s = (row_r == H_LAST) && last_col_s;
        if ((row_r == '0) || (row_r == H_LAST)) begin
            if (last_col_s) begin
                brow_s = row_r + ONE_A;
                bcol_s = '0;
            end else begin
                bcol_s = col_r + ONE_A;
            end
        end else begin
            if (col_r == '0) begin
                bcol_s = W_LAST;
            end else begin
                brow_s = row_r + ONE_A;
                bcol_s = '0;
            end
        end
    end
`endif

    // Control FSM, window registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            row_r     <= '0;
            col_r     <= '0;
            ph_r      <= 2'd0;
            last_r    <= 1'b0;
            thr_r     <= '0;
            top_r     <= '0;
            mid_r     <= '0;
            for (int i = 0; i < 3; i++) begin
                left_r[i] <= '0;
                cent_r[i] <= '0;
            end
            gray_req  <= 1'b0;
            gray_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= 8'h00;
            finish    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gray_ready) begin
                        thr_r  <= thr;
                        ph_r   <= 2'd0;
                        last_r <= 1'b0;
`ifdef LBP_BORDER_WR_EN
                        row_r     <= '0;
                        col_r     <= '0;
                        lbp_valid <= 1'b1;
                        lbp_addr  <= '0;
                        lbp_data  <= 8'h00;
                        state_r   <= BORDER;
`else
                        row_r     <= ONE_A;
                        col_r     <= '0;
                        gray_req  <= 1'b1;
                        gray_addr <= '0;
                        state_r   <= FETCH;
`endif
                    end
                end
`ifdef LBP_BORDER_WR_EN
                BORDER: begin
                    if (border_end_s) begin
                        lbp_valid <= 1'b0;
                        row_r     <= ONE_A;
                        col_r     <= '0;
                        gray_req  <= 1'b1;
                        gray_addr <= '0;
                        state_r   <= FETCH;
                    end else begin
                        row_r     <= brow_s;
                        col_r     <= bcol_s;
                        lbp_valid <= 1'b1;
                        lbp_addr  <= addr_of(brow_s, bcol_s);
                        lbp_data  <= 8'h00;
                    end
                end
`endif
                FETCH: begin
                    if (last_r) begin
                        lbp_valid <= 1'b0;
                        finish    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        case (ph_r)
                            2'd0: begin
                                top_r     <= gray_data;
                                lbp_valid <= 1'b0;
                            end
                            2'd1: begin
                                mid_r     <= gray_data;
                                lbp_valid <= 1'b0;
                            end
                            2'd2: begin
                                for (int i = 0; i < 3; i++) begin
                                    left_r[i] <= cent_r[i];
                                end
                                cent_r[0] <= top_r;
                                cent_r[1] <= mid_r;
                                cent_r[2] <= gray_data;
                                lbp_valid <= (col_r >= TWO_A);
                                lbp_addr  <= addr_of(row_r, col_r - ONE_A);
                                lbp_data  <= code_s;
                            end
                            default: begin
                                lbp_valid <= 1'b0;
                            end
                        endcase
                        if (frame_end_s) begin
                            gray_req <= 1'b0;
                            last_r   <= 1'b1;
                        end else begin
                            gray_req  <= 1'b1;
                            gray_addr <= fetch_addr_s;
                            row_r     <= nrow_s;
                            col_r     <= ncol_s;
                            ph_r      <= nph_s;
                        end
                    end
                end
                DONE: begin
                    gray_req  <= 1'b0;
                    lbp_valid <= 1'b0;
                    finish    <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    gray_req  <= 1'b0;
                    lbp_valid <= 1'b0;
                    finish    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_engine_param.sv
// Self-checking bench for lbp_engine_param: three instances (4x4, 3x3, 11x7/6-bit),
// table-driven flat images, a gradient window, random frames against a
// reference model, start gating and a mid-frame reset. Follows LBP_BORDER_WR_EN.
module tb_lbp_engine_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic       req;
        logic [7:0] gaddr;
        logic       valid;
        logic [7:0] laddr;
        logic [7:0] ldata;
        logic       fin;
    } outs_t;

    typedef struct {
        int         pix;
        int         thr;
        logic [7:0] code;
    } vec_t;

    wr_t qa[$];
    wr_t qb[$];
    wr_t qc[$];
    wr_t ea, eb, ec;

    // Instance A: 4x4, 8-bit pixels
    logic       a_reset, a_ready, a_req, a_valid, a_fin;
    logic [3:0] a_gaddr, a_laddr;
    logic [7:0] a_gdata, a_thr, a_ldata;
    logic [7:0] mem_a [16];
    assign a_gdata = mem_a[a_gaddr];

    lbp_engine_param #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4)) dut_a (
        .clk(clk), .reset(a_reset), .gray_ready(a_ready), .gray_req(a_req),
        .gray_addr(a_gaddr), .gray_data(a_gdata), .thr(a_thr),
        .lbp_valid(a_valid), .lbp_addr(a_laddr), .lbp_data(a_ldata), .finish(a_fin));

    // Instance B: 3x3, 8-bit pixels
    logic       b_reset, b_ready, b_req, b_valid, b_fin;
    logic [3:0] b_gaddr, b_laddr;
    logic [7:0] b_gdata, b_thr, b_ldata;
    logic [7:0] mem_b [16];
    assign b_gdata = mem_b[b_gaddr];

    lbp_engine_param #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .ADDR_W(4)) dut_b (
        .clk(clk), .reset(b_reset), .gray_ready(b_ready), .gray_req(b_req),
        .gray_addr(b_gaddr), .gray_data(b_gdata), .thr(b_thr),
        .lbp_valid(b_valid), .lbp_addr(b_laddr), .lbp_data(b_ldata), .finish(b_fin));

    // Instance C: 11x7, 6-bit pixels
    logic       c_reset, c_ready, c_req, c_valid, c_fin;
    logic [6:0] c_gaddr, c_laddr;
    logic [5:0] c_gdata, c_thr;
    logic [7:0] c_ldata;
    logic [7:0] mem_c [128];
    assign c_gdata = mem_c[c_gaddr][5:0];

    lbp_engine_param #(.IMG_W(11), .IMG_H(7), .PIX_W(6), .ADDR_W(7)) dut_c (
        .clk(clk), .reset(c_reset), .gray_ready(c_ready), .gray_req(c_req),
        .gray_addr(c_gaddr), .gray_data(c_gdata), .thr(c_thr),
        .lbp_valid(c_valid), .lbp_addr(c_laddr), .lbp_data(c_ldata), .finish(c_fin));

    int bf_exp [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    int bf_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int border_cnt(input int w, input int h);
`ifdef LBP_BORDER_WR_EN
        return w * h - (w - 2) * (h - 2);
`else
        return 0;
`endif
    endfunction

    function automatic outs_t outs(input int inst);
        outs_t o;
        case (inst)
            0: o = {a_req, 4'd0, a_gaddr, a_valid, 4'd0, a_laddr, a_ldata, a_fin};
            1: o = {b_req, 4'd0, b_gaddr, b_valid, 4'd0, b_laddr, b_ldata, b_fin};
            2: o = {c_req, 1'b0, c_gaddr, c_valid, 1'b0, c_laddr, c_ldata, c_fin};
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic int px(input int inst, input int idx);
        case (inst)
            0: return int'(mem_a[idx]);
            1: return int'(mem_b[idx]);
            default: return int'(mem_c[idx]);
        endcase
    endfunction

    function automatic int qsize(input int inst);
        case (inst)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic qpush(input int inst, input int addr, input int data);
        wr_t e;
        e.addr = addr[7:0];
        e.data = data[7:0];
        case (inst)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic set_ready(input int inst, input logic v);
        case (inst)
            0: a_ready = v;
            1: b_ready = v;
            default: c_ready = v;
        endcase
    endtask

    task automatic set_reset(input int inst, input logic v);
        case (inst)
            0: a_reset = v;
            1: b_reset = v;
            default: c_reset = v;
        endcase
    endtask

    // Threshold changes after start must not affect the running frame.
    task automatic scramble_thr(input int inst);
        case (inst)
            0: a_thr = ~a_thr;
            1: b_thr = ~b_thr;
            default: c_thr = ~c_thr;
        endcase
    endtask

    task automatic push_border(input int inst, input int w, input int h);
`ifdef LBP_BORDER_WR_EN
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if (r == 0 || r == h - 1 || c == 0 || c == w - 1)
                    qpush(inst, r * w + c, 0);
`endif
    endtask

    // Reference LBP model over the bench's image memory.
    task automatic push_model(input int inst, input int w, input int h, input int thr);
        int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        push_border(inst, w, h);
        for (int r = 1; r < h - 1; r++) begin
            for (int c = 1; c < w - 1; c++) begin
                int gc, code;
                gc = px(inst, r * w + c);
                code = 0;
                for (int k = 0; k < 8; k++)
                    if (px(inst, (r + dr[k]) * w + c + dc[k]) >= gc + thr)
                        code = code | (1 << k);
                qpush(inst, r * w + c, code);
            end
        end
    endtask

    // Start a frame, check first cycle, finish latency and hold, then reset.
    task automatic run_frame(input int inst, input int w, input int h, input string tag);
        int    exp_k;
        bit    seen;
        outs_t o;
        exp_k = 3 * w * (h - 2) + 2 + border_cnt(w, h);
        seen  = 1'b0;
        @(negedge clk);
        set_ready(inst, 1'b1);
        for (int k = 1; k <= exp_k + 20 && !seen; k++) begin
            @(negedge clk);
            o = outs(inst);
            if (k == 1) begin
`ifdef LBP_BORDER_WR_EN
                chk({tag, "_first_border_wr"}, {o.req, o.valid, o.laddr}, {1'b0, 1'b1, 8'd0});
`else
                chk({tag, "_first_req"}, {o.req, o.gaddr}, {1'b1, 8'd0});
`endif
            end
            if (k == 2) begin
                set_ready(inst, 1'b0);
                scramble_thr(inst);
            end
            if (o.fin === 1'b1) begin
                seen = 1'b1;
                chk({tag, "_finish_cycle"}, k, exp_k);
            end
        end
        if (!seen) chk({tag, "_finish_timeout"}, 0, 1);
        @(negedge clk);
        o = outs(inst);
        chk({tag, "_done_hold"}, {o.fin, o.req, o.valid}, {1'b1, 1'b0, 1'b0});
        chk({tag, "_writes_left"}, qsize(inst), 0);
        set_reset(inst, 1'b0);
        repeat (2) @(negedge clk);
        set_reset(inst, 1'b1);
    endtask

    // Scoreboards: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            if (qa.size() == 0) chk("a_extra_write", {28'd0, a_laddr}, 32'hFFFF_FFFF);
            else begin
                ea = qa.pop_front();
                chk("a_wr_addr", {28'd0, a_laddr}, {24'd0, ea.addr});
                chk("a_wr_data", {24'd0, a_ldata}, {24'd0, ea.data});
            end
        end
        if (b_valid === 1'b1) begin
            if (qb.size() == 0) chk("b_extra_write", {28'd0, b_laddr}, 32'hFFFF_FFFF);
            else begin
                eb = qb.pop_front();
                chk("b_wr_addr", {28'd0, b_laddr}, {24'd0, eb.addr});
                chk("b_wr_data", {24'd0, b_ldata}, {24'd0, eb.data});
            end
        end
        if (c_valid === 1'b1) begin
            if (qc.size() == 0) chk("c_extra_write", {25'd0, c_laddr}, 32'hFFFF_FFFF);
            else begin
                ec = qc.pop_front();
                chk("c_wr_addr", {25'd0, c_laddr}, {24'd0, ec.addr});
                chk("c_wr_data", {24'd0, c_ldata}, {24'd0, ec.data});
            end
        end
        if (b_req === 1'b1) begin
            if (bf_idx < 9) chk("b_fetch_order", {28'd0, b_gaddr}, bf_exp[bf_idx]);
            else chk("b_extra_fetch", {28'd0, b_gaddr}, 32'hFFFF_FFFF);
            bf_idx++;
        end
    end

    vec_t  tbl [7];
    outs_t o0;
    int    nfetch;

    initial begin
        tbl[0] = '{50, 0, 8'hFF};
        tbl[1] = '{50, 1, 8'h00};
        tbl[2] = '{0, 0, 8'hFF};
        tbl[3] = '{255, 0, 8'hFF};
        tbl[4] = '{254, 1, 8'h00};
        tbl[5] = '{255, 1, 8'h00};
        tbl[6] = '{7, 200, 8'h00};

        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        for (int i = 0; i < 128; i++) mem_c[i] = 8'd0;
        a_thr = 8'd0; b_thr = 8'd0; c_thr = 6'd0;

        // Reset held with gray_ready high: everything quiet.
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o0 = outs(i);
            chk($sformatf("reset_outs_%0d", i), {5'd0, o0}, 32'd0);
        end

        // Release with gray_ready low: no request may appear.
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("start_gating", {a_req, b_req, c_req}, 3'b000);
        end

        // Flat 4x4 images from the table.
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 16; i++) mem_a[i] = tbl[t].pix[7:0];
            a_thr = tbl[t].thr[7:0];
            push_border(0, 4, 4);
            qpush(0, 5, tbl[t].code);
            qpush(0, 6, tbl[t].code);
            qpush(0, 9, tbl[t].code);
            qpush(0, 10, tbl[t].code);
            run_frame(0, 4, 4, "a");
        end

        // Gradient 3x3 window.
        for (int i = 0; i < 9; i++) mem_b[i] = 8'((i + 1) * 10);
        b_thr = 8'd0;
        push_border(1, 3, 3);
        qpush(1, 4, 8'hF0);
        run_frame(1, 3, 3, "b");
        chk("b_fetch_count", bf_idx, 9);

        // Random 11x7 frames with small and large thresholds.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 77; i++) mem_c[i] = 8'($urandom_range(0, 63));
            c_thr = (t == 2) ? 6'd40 : 6'($urandom_range(0, 4));
            push_model(2, 11, 7, int'(c_thr));
            run_frame(2, 11, 7, "c");
        end

        // Mid-frame reset at the 100th fetch cycle, then a clean rerun.
        for (int i = 0; i < 77; i++) mem_c[i] = 8'($urandom_range(0, 63));
        c_thr = 6'd1;
        push_model(2, 11, 7, 1);
        @(negedge clk);
        c_ready = 1'b1;
        nfetch = 0;
        for (int k = 0; k < 400 && nfetch < 100; k++) begin
            @(negedge clk);
            c_ready = 1'b0;
            if (c_req === 1'b1) nfetch++;
        end
        chk("c_reached_fetch100", nfetch, 100);
        c_reset = 1'b0;
        @(negedge clk);
        o0 = outs(2);
        chk("c_midreset_outs", {5'd0, o0}, 32'd0);
        qc.delete();
        @(negedge clk);
        c_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("c_idle_after_reset", {c_req, c_valid, c_fin}, 3'b000);
        c_thr = 6'd1;
        push_model(2, 11, 7, 1);
        run_frame(2, 11, 7, "c_rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lbp_engine_param.md
Name: lbp_engine_param

Overview:
- Parametrised local-binary-pattern engine; successor to the fixed 128x128/8-bit LBP core.
- Reads a grey image from the external gray memory through a request interface.
- Writes one 8-bit LBP code per interior pixel to the lbp result memory.
- Adds configurable image size, configurable pixel width, a programmable compare threshold and 3x3 column-reuse fetching.

Parameters:
- IMG_W, 128, image width in pixels (>=3)
- IMG_H, 128, image height in pixels (>=3)
- PIX_W, 8, grey pixel width in bits
- ADDR_W, 14, address width; must be >= clog2(IMG_W*IMG_H)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- gray_ready  in  1  source image ready; start qualifier
- gray_req  out  1  pixel read request
- gray_addr  out  ADDR_W  pixel address = row*IMG_W+col
- gray_data  in  PIX_W  pixel; valid at the clk edge ending the cycle in which gray_req=1
- thr  in  PIX_W  compare threshold; sampled on the IDLE->FETCH transition
- lbp_valid  out  1  result write strobe
- lbp_addr  out  ADDR_W  result address
- lbp_data  out  8  LBP code
- finish  out  1  frame complete

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data and finish are all 0.
- Reset has priority over every state, including mid-frame. Partial results are abandoned; nothing is written after reset is sampled.
- States: IDLE -> FETCH -> DONE.
- IDLE: waits for gray_ready=1, then latches thr, sets row=1, col=0, goes to FETCH.
- FETCH: for the current centre row r, fetches column c as three requests on consecutive cycles: (r-1,c), (r,c), (r+1,c).
  - gray_req=1 every FETCH cycle; no idle gaps within a row.
  - Fetched columns shift into a 3x3 window register (3 columns x 3 rows).
- Output timing:
  - Once columns c-2..c are loaded (c>=2), lbp_valid=1 for exactly one cycle, the cycle after the third pixel of column c is captured.
  - That cycle overlaps the first fetch of the next column.
  - lbp_addr = r*IMG_W+(c-1).
  - Throughput: one result per 3 cycles.
- Row end: after col=IMG_W-1, row increments and col returns to 0. The window is refilled from column 0; no results are produced for the first two columns of a row.
- Row IMG_H-2 is the last row. After its last result, go to DONE.
- DONE: finish=1 from the cycle after the last lbp_valid, held until reset. gray_req=0 and lbp_valid=0 in DONE.
- LBP code, with centre g_c:
  - Neighbours g0..g7 = TL, T, TR, L, R, BL, B, BR; code bit k has weight 2^k.
  - bit k = 1 iff g_k >= g_c + thr.
  - The sum is computed in PIX_W+1 bits with no saturation, so g_c+thr > 2^PIX_W-1 forces the bit to 0.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never written; memory init supplies 0.
- Total frame cycles from start to finish = 3*IMG_W*(IMG_H-2)+2. For 128x128 this is 48386.
- gray_ready falling mid-frame is ignored; it is only sampled in IDLE.
- All address arithmetic is modulo 2^ADDR_W. Configurations with ADDR_W too small are illegal; no check is required.

Optional Feature:
- Macro: LBP_BORDER_WR_EN
- Defined: the engine also writes lbp_data=0 to every border address.
  - The 2*IMG_W-2*... border set covers exactly IMG_W*IMG_H-(IMG_W-2)*(IMG_H-2) addresses.
  - Border writes are issued in a BORDER state between IDLE and FETCH, one per cycle in ascending address order, with gray_req=0.
  - finish latency grows by the border count (508 cycles for 128x128).
- Undefined: behaviour exactly as above; the BORDER state does not exist.

Test Plan:
- Reset: hold reset=0 for 2 cycles with gray_ready=1 -> gray_req, lbp_valid, finish, gray_addr and lbp_addr all 0; no memory writes.
- Flat image, IMG_W=IMG_H=4, all pixels 50, thr=0 -> exactly 4 writes, 0xFF to addresses 5, 6, 9, 10, then finish=1 one cycle after the 4th write. Same image with thr=1 -> all four codes 0x00.
- Gradient window, IMG_W=IMG_H=3, pixels 10,20,30,40,50,60,70,80,90 (row-major), thr=0 -> single write lbp_addr=4, lbp_data=0xF0; fetch order 0,3,6,1,4,7,2,5,8.
- Start gating: keep gray_ready=0 for 20 cycles after reset release -> gray_req stays 0. Raise gray_ready -> first gray_req/gray_addr=0 on the next cycle.
- Mid-frame reset: assert reset at the 100th FETCH cycle of a 128x128 frame -> all outputs 0 the next cycle. After release and gray_ready, a full frame reruns with correct results.
- Full frame, 128x128, pattern1/golden1, thr=0 -> all 16384 locations match golden; finish rises 48386 cycles after start. With LBP_BORDER_WR_EN, results are identical, 508 extra writes occur, and finish rises at 48894.
